// File: rtl/sum_block_accum.sv
// sum_block_accum
//   Accumulates a programmed number of unsigned DATA_W-bit sums from the
//   registered adder stage into a saturating ACC_W-bit total. It presents the
//   block result on a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a block (honoured only while idle)
//   num_samples  samples per block, captured on the accepted start
//   in_valid     in_data carries a valid sum this cycle
//   in_data      unsigned sum from the adder stage
//   out_ready    consumer takes the result this cycle
//   out_valid    out_sum/out_ovf hold a completed block result
//   out_sum      block total, saturated at all ones
//   out_ovf      saturation occurred somewhere in the block
//   busy         block in progress or result pending
module sum_block_accum #(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic             out_ovf_q, out_ovf_d;
   logic             busy_q, busy_d;

   // One extra bit so the carry out of the accumulator reveals saturation.
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] acc_upd;
   logic             ovf_upd;
   logic [CNT_W-1:0] last_cnt;

   assign sum_ext  = {1'b0, acc_q} + {{(ACC_W+1-DATA_W){1'b0}}, in_data};
   assign acc_upd  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
   assign ovf_upd  = ovf_q | sum_ext[ACC_W];
   // target is never zero in ACCUM, so this does not underflow there.
   assign last_cnt = target_q - CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      target_d    = target_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_samples != '0) begin
                  target_d = num_samples;
                  acc_d    = '0;
                  cnt_d    = '0;
                  ovf_d    = 1'b0;
                  state_d  = ACCUM;
               end else begin
                  // Empty block: report a zero result straight away.
                  out_sum_d   = '0;
                  out_ovf_d   = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = acc_upd;
               ovf_d = ovf_upd;
               cnt_d = cnt_q + CNT_W'(1);
               // Final sample: publish the updated value on this same edge.
               if (cnt_q == last_cnt) begin
                  out_sum_d   = acc_upd;
                  out_ovf_d   = ovf_upd;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            // start is deliberately ignored here, even alongside out_ready.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         target_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         target_q    <= target_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sum_block_accum.sv
// tb_sum_block_accum
//   Directed testbench for sum_block_accum. Inputs change 1 time unit after
//   each rising edge. Outputs are checked at that same point.
module tb_sum_block_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  num_samples = '0;
   logic        in_valid = 1'b0;
   logic [11:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_sum;
   logic        out_ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   sum_block_accum dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_sum     (out_sum),
      .out_ovf     (out_ovf),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] s,
                          input logic o, input logic b);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".sum"},   32'(out_sum),   32'(s));
      chk({tag, ".ovf"},   32'(out_ovf),   32'(o));
      chk({tag, ".busy"},  32'(busy),      32'(b));
   endtask

   task automatic start_block(input logic [7:0] n);
      start = 1'b1; num_samples = n;
      step();
      start = 1'b0;
   endtask

   task automatic sample(input logic [11:0] d);
      in_valid = 1'b1; in_data = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      #3;
      chk_out("reset", 1'b0, 16'd0, 1'b0, 1'b0);
      #9 rst = 1'b0;
      step();

      // Block of 4: 1+2+3+4
      start_block(8'd4);
      chk_out("b4_start", 1'b0, 16'd0, 1'b0, 1'b1);
      sample(12'd1); sample(12'd2); sample(12'd3);
      chk("b4_3rd.valid", 32'(out_valid), 32'd0);
      sample(12'd4);
      chk_out("b4_done", 1'b1, 16'd10, 1'b0, 1'b1);
      accept();
      chk_out("b4_idle", 1'b0, 16'd10, 1'b0, 1'b0);

      // Block of 3 with gaps, then a held result with in_valid noise in DONE
      start_block(8'd3);
      sample(12'd100);
      step(); step();
      sample(12'd200);
      sample(12'd300);
      chk_out("b3_done", 1'b1, 16'd600, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0]; in_data = 12'd50;
         step();
         chk("b3_hold.valid", 32'(out_valid), 32'd1);
         chk("b3_hold.sum", 32'(out_sum), 32'd600);
      end
      in_valid = 1'b0;
      accept();
      chk_out("b3_idle", 1'b0, 16'd600, 1'b0, 1'b0);

      // 16 x 4095 = 65520 still fits
      start_block(8'd16);
      for (int i = 0; i < 16; i++) sample(12'd4095);
      chk_out("b16_done", 1'b1, 16'd65520, 1'b0, 1'b1);
      accept();

      // 17 x 4095 saturates
      start_block(8'd17);
      for (int i = 0; i < 16; i++) sample(12'd4095);
      chk("b17_16th.valid", 32'(out_valid), 32'd0);
      sample(12'd4095);
      chk_out("b17_done", 1'b1, 16'd65535, 1'b1, 1'b1);
      accept();

      // Next block starts clean: ovf cleared
      start_block(8'd1);
      sample(12'd5);
      chk_out("b1_done", 1'b1, 16'd5, 1'b0, 1'b1);
      accept();

      // num_samples = 0 goes straight to DONE with zero
      start_block(8'd0);
      chk_out("b0_done", 1'b1, 16'd0, 1'b0, 1'b1);
      accept();
      chk_out("b0_idle", 1'b0, 16'd0, 1'b0, 1'b0);

      // start in ACCUM is ignored
      start_block(8'd2);
      sample(12'd7);
      start = 1'b1; num_samples = 8'd5;
      step();
      start = 1'b0;
      chk("b2_ign.valid", 32'(out_valid), 32'd0);
      sample(12'd8);
      chk_out("b2_done", 1'b1, 16'd15, 1'b0, 1'b1);
      accept();

      // Asynchronous reset mid-block
      start_block(8'd5);
      sample(12'd3); sample(12'd3);
      #2 rst = 1'b1;
      #1;
      chk_out("arst", 1'b0, 16'd0, 1'b0, 1'b0);
      #3 rst = 1'b0;
      step();
      start_block(8'd2);
      sample(12'd9); sample(12'd9);
      chk_out("post_rst", 1'b1, 16'd18, 1'b0, 1'b1);
      accept();

      // start together with out_ready in DONE returns to IDLE only
      start_block(8'd1);
      sample(12'd4);
      chk_out("sr_done", 1'b1, 16'd4, 1'b0, 1'b1);
      start = 1'b1; num_samples = 8'd1; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_out("sr_idle", 1'b0, 16'd4, 1'b0, 1'b0);
      step();
      start = 1'b0;
      chk_out("sr_accum", 1'b0, 16'd4, 1'b0, 1'b1);
      sample(12'd6);
      chk_out("sr_done2", 1'b1, 16'd6, 1'b0, 1'b1);
      accept();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
